// File: rtl/serial_frame_deserializer.sv
// serial_frame_deserializer
// Receive end of the serial shift link. Recovers start/data/stop framed words
// from a strobed serial line, with per-frame selectable bit order. Each good
// word is offered through a valid/ready holding register.
//
// Ports:
//   clk        rising-edge clock
//   clear_n    asynchronous active-low reset, clears all state
//   ser_in     serial line (idle high)
//   ser_valid  bit strobe; ser_in is sampled only when high
//   lsb_first  bit order for the next frame (1: first data bit -> data_out[0])
//   out_ready  consumer accepts data_out while out_valid is high
//   err_clr    synchronous clear of the sticky overrun flag
//   data_out   received word
//   out_valid  data_out holds an unconsumed word
//   busy       frame in progress (DATA or STOP)
//   frame_err  one-cycle pulse on a bad stop bit
//   overrun    sticky: a good word was dropped because the holding register was full
module serial_frame_deserializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             lsb_first,
  input  logic             out_ready,
  input  logic             err_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;

  // State and output registers
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state, shifting, handshake and error flags
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = ovr_q;

    if (valid_q && out_ready) valid_d = 1'b0;
    if (err_clr) ovr_d = 1'b0;

    if (ser_valid) begin
      case (state_q)
        IDLE: begin
          if (!ser_in) begin
            dir_d   = lsb_first;
            cnt_d   = '0;
            state_d = DATA;
          end
        end
        DATA: begin
          // LSB-first enters at the MSB and drifts down to bit 0; MSB-first the reverse
          if (dir_q) shift_d = {ser_in, shift_q[WIDTH-1:1]};
          else       shift_d = {shift_q[WIDTH-2:0], ser_in};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (ser_in) begin
            // A consume in the same cycle frees the register for this word
            if (!valid_q || out_ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Testbench for serial_frame_deserializer: scoreboard of expected words,
// popped by a monitor whenever the DUT hands a word over.
module tb_serial_frame_deserializer;

  localparam int unsigned W = 8;

  logic         clk;
  logic         clear_n;
  logic         ser_in;
  logic         ser_valid;
  logic         lsb_first;
  logic         out_ready;
  logic         err_clr;
  logic [W-1:0] data_out;
  logic         out_valid;
  logic         busy;
  logic         frame_err;
  logic         overrun;

  int unsigned  n_chk;
  int unsigned  n_pass;
  logic [W-1:0] sb_q[$];

  serial_frame_deserializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .ser_in    (ser_in),
    .ser_valid (ser_valid),
    .lsb_first (lsb_first),
    .out_ready (out_ready),
    .err_clr   (err_clr),
    .data_out  (data_out),
    .out_valid (out_valid),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Handshake monitor: a transfer happens at the next rising edge
  always @(negedge clk) begin
    if (clear_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      else chk("word", 32'(data_out), 32'(sb_q.pop_front()));
    end
  end

  task automatic drive_bit(input logic b, input int gap);
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
    end
    ser_valid = 1'b1;
    ser_in    = b;
    @(posedge clk); #1;
    ser_valid = 1'b0;
    ser_in    = 1'b1;
  endtask

  // Sends start, WIDTH data bits in the chosen order, then the given stop bit
  task automatic send_frame(input logic [W-1:0] word, input logic lsbf, input logic stop,
                            input bit toggle, input int gap, input bit rdy_en, input logic rdy);
    lsb_first = lsbf;
    drive_bit(1'b0, gap);
    chk("busy_start", 32'(busy), 32'd1);
    for (int i = 0; i < int'(W); i++) begin
      if (toggle && i == 2) lsb_first = ~lsbf;
      drive_bit(lsbf ? word[i] : word[int'(W) - 1 - i], gap);
    end
    if (rdy_en) out_ready = rdy;
    drive_bit(stop, gap);
  endtask

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    clear_n   = 1'b0;
    ser_in    = 1'b1;
    ser_valid = 1'b0;
    lsb_first = 1'b1;
    out_ready = 1'b1;
    err_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", 32'({data_out, out_valid, busy, frame_err, overrun}), 32'd0);
    @(negedge clk);
    clear_n = 1'b1;
    @(posedge clk); #1;

    // Idle line with strobes
    for (int i = 0; i < 4; i++) begin
      drive_bit(1'b1, 0);
      chk("idle", 32'({out_valid, busy, frame_err, overrun}), 32'd0);
    end

    // LSB-first 1,0,1,0,0,1,1,0 -> 0x65
    sb_q.push_back(8'h65);
    send_frame(8'h65, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    chk("lsb_valid", 32'(out_valid), 32'd1);
    chk("lsb_data", 32'(data_out), 32'h65);
    chk("lsb_idle", 32'(busy), 32'd0);

    // Same bit sequence MSB-first -> 0xA6, with lsb_first toggled mid-frame
    sb_q.push_back(8'hA6);
    send_frame(8'hA6, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    chk("msb_data", 32'(data_out), 32'hA6);

    // Spaced strobes
    sb_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0);
    chk("gap_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;

    // Bad stop bit
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    chk("ferr_pulse", 32'(frame_err), 32'd1);
    chk("ferr_novalid", 32'(out_valid), 32'd0);
    chk("ferr_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("ferr_onecyc", 32'(frame_err), 32'd0);
    sb_q.push_back(8'h81);
    send_frame(8'h81, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    chk("after_ferr", 32'(data_out), 32'h81);
    chk("no_ovr0", 32'(overrun), 32'd0);
    @(posedge clk); #1;

    // Overrun: holding register full and not consumed
    out_ready = 1'b0;
    sb_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    chk("ovr_keep", 32'(data_out), 32'h11);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_valid", 32'(out_valid), 32'd1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'd0);

    // Consume and load in the same stop cycle
    sb_q.push_back(8'h22);
    send_frame(8'h22, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b1);
    out_ready = 1'b0;
    chk("swap_data", 32'(data_out), 32'h22);
    chk("swap_valid", 32'(out_valid), 32'd1);
    chk("swap_no_ovr", 32'(overrun), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("drained", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-frame
    lsb_first = 1'b1;
    drive_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 0);
    #2;
    clear_n = 1'b0;
    #1;
    chk("arst_outs", 32'({data_out, out_valid, busy, frame_err, overrun}), 32'd0);
    @(negedge clk);
    clear_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_idle", 32'(busy), 32'd0);
    sb_q.push_back(8'hF0);
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    chk("arst_data", 32'(data_out), 32'hF0);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_frame_deserializer.md
Name: serial_frame_deserializer

Overview:
- Receive end of the team's serial shift link: converts a start/data/stop framed serial bit stream back into parallel words.
- Mirrors the shift-left/shift-right capability of the transmit-side shift register: the bit order is selectable per frame.
- Delivers each completed word through a valid/ready output holding register.
- Flags framing errors and overruns.

Parameters:
- WIDTH, 8, data bits per frame (legal range 2..16).

Ports:
- clk  input  1  rising-edge clock
- clear_n  input  1  asynchronous active-low reset; clears all state
- ser_in  input  1  serial line; idle level is 1
- ser_valid  input  1  bit strobe; ser_in is sampled only on cycles where this is 1
- lsb_first  input  1  1 = first data bit received goes to data_out[0] (shift right); 0 = first data bit goes to data_out[WIDTH-1] (shift left)
- out_ready  input  1  consumer accepts data_out when out_valid=1
- err_clr  input  1  synchronous clear of the sticky overrun flag
- data_out  output  WIDTH  received word
- out_valid  output  1  data_out holds an unconsumed word
- busy  output  1  high while a frame is in progress (DATA or STOP state)
- frame_err  output  1  one-cycle pulse when a bad stop bit is detected
- overrun  output  1  sticky; a good frame was dropped because the holding register was full

Behaviour:
- Reset (clear_n=0, asynchronous):
  - state=IDLE; shift register, bit counter, data_out, out_valid, busy, frame_err and overrun all go to 0.
  - Reset asserted mid-frame abandons the partial frame; no output is produced.
- All state advances only on clk rising edges where ser_valid=1. Exceptions: out_valid/out_ready handshake, err_clr and the frame_err pulse clearing.
- FSM states IDLE, DATA, STOP:
  - IDLE: on ser_valid with ser_in=0 (start bit): latch lsb_first into frame_dir, clear counter, go to DATA. ser_in=1 stays in IDLE.
  - DATA: on each ser_valid, shift ser_in in and increment the counter.
    - frame_dir=1: new bit enters at MSB; the register shifts toward bit 0.
    - frame_dir=0: new bit enters at bit 0; the register shifts toward MSB.
    - After the WIDTH-th data bit (counter = WIDTH-1 when sampled), go to STOP.
  - STOP: on ser_valid, always return to IDLE.
    - ser_in=1 (good frame): deliver the word per the load rule below.
    - ser_in=0: frame_err pulses high for exactly the next cycle and the word is discarded.
    - No back-to-back start detection occurs in the stop-bit cycle.
- busy = 1 in DATA and STOP.
- lsb_first changes during a frame have no effect until the next start bit.
- Load rule at a good stop bit:
  - If out_valid=0, or out_valid=1 and out_ready=1 in the same cycle: data_out <= shift register and out_valid=1 next cycle. A simultaneous consume and load is legal and is not an overrun.
  - Else (holding register full, not consumed): keep the old data_out, drop the new word, set overrun=1.
- Handshake:
  - out_valid falls on the cycle after out_valid&&out_ready unless a new load occurs in that same cycle.
  - data_out is stable while out_valid=1 and out_ready=0.
- overrun stays set until err_clr=1 or reset. If err_clr and a new overrun occur in the same cycle, overrun remains 1.
- Latency: out_valid rises 1 clk after the stop-bit sample cycle.
- Minimum frame length is WIDTH+2 strobes. Strobes may be spaced arbitrarily, including back-to-back every cycle.

Test Plan:
- Reset then idle line: ser_in=1 held with ser_valid strobes -> out_valid, busy, frame_err and overrun all remain 0.
- LSB-first: lsb_first=1, send start 0, data bits 1,0,1,0,0,1,1,0, stop 1 with ser_valid every cycle -> data_out=8'h65, out_valid=1 one clk after the stop sample.
- MSB-first, same bit sequence with lsb_first=0 -> data_out=8'hA6. Toggle lsb_first mid-frame -> result unchanged.
- Bad stop: send frame 8'h3C with stop bit 0 -> frame_err high for exactly 1 cycle, out_valid stays 0, FSM returns to IDLE. The next good frame 8'h81 is received correctly.
- Overrun: receive 8'h11 with out_ready=0, then a good frame 8'h22 -> data_out stays 8'h11 and overrun=1. Pulse err_clr -> overrun=0. Repeat with out_ready=1 in the stop cycle -> data_out=8'h22, no overrun.
- Async reset: drive clear_n=0 after 4 data bits (between clock edges) -> all outputs 0 immediately, FSM in IDLE. A fresh full frame 8'hF0 then decodes correctly.
